// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Definitions shared by the UART receive and transmit paths.
//  Contents:
//   UART_CLKS_PER_BIT  default clk cycles per bit period (50 MHz / 115200)
//   UART_DATA_BITS     data bits per 8N1 frame
//   uart_state_t       receiver FSM state encoding
//   half_bit_cycles()  cycles from a start-bit detect to mid-bit
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 434;
   localparam int UART_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } uart_state_t;

   // Mid-bit offset used when qualifying a start bit.
   function automatic int half_bit_cycles(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//  Two-flop synchroniser for asynchronous inputs. Each bit is synchronised
//  on its own; use it only for signals whose bits are independent.
//  Parameters:
//   WIDTH      number of independent bits (1 for a serial line)
//   RESET_VAL  value both flops take during reset
//  Ports:
//   clk    in   1      system clock
//   reset  in   1      synchronous, active-high reset
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output, two clk cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int   WIDTH     = 1,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               meta_reg <= RESET_VAL;
               sync_reg <= RESET_VAL;
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//  8N1 serial receiver. rx_in is synchronised, a start bit is qualified at
//  mid-bit, then the eight data bits (LSB first) and the stop bit are
//  sampled once per bit period at the bit centre. A good frame produces a
//  one-cycle rx_data_valid pulse; a low stop bit produces a one-cycle
//  framing_error pulse and the receiver waits for the line to return high.
//  Parameters:
//   CLKS_PER_BIT   clk cycles per bit period, >= 4
//  Ports:
//   clk            in   1  system clock
//   reset          in   1  synchronous, active-high reset
//   rx_in          in   1  asynchronous serial line, idles high
//   rx_data        out  8  last good byte received
//   rx_data_valid  out  1  one-cycle pulse: rx_data holds a new byte
//   rx_busy        out  1  high whenever the FSM is not idle
//   framing_error  out  1  one-cycle pulse: stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   output logic       rx_busy,
   output logic       framing_error
);

   localparam int HALF_BIT = half_bit_cycles(CLKS_PER_BIT);
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT_IDX  = 3'(UART_DATA_BITS - 1);

   uart_state_t             state_reg;
   logic        [CNT_W-1:0] cnt_reg;
   logic        [2:0]       bit_idx_reg;
   logic        [7:0]       shift_reg;
   logic                    rx_s;

   // Line resets to the idle level so a reset never looks like a start bit.
   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync_rx (
      .clk   (clk),
      .reset (reset),
      .d     (rx_in),
      .q     (rx_s)
   );

   // rx_busy is updated together with every state change so it always
   // equals (state_reg != ST_IDLE) without a combinational decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         rx_busy       <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         rx_data_valid <= 1'b0;
         framing_error <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               cnt_reg <= '0;
               if (!rx_s) begin
                  state_reg <= ST_START;
                  rx_busy   <= 1'b1;
               end
            end

            // Re-check the line half a bit later; a high level here was a
            // glitch and is dropped silently.
            ST_START: begin
               if (cnt_reg == CNT_HALF_LAST) begin
                  cnt_reg <= '0;
                  if (!rx_s) begin
                     state_reg   <= ST_DATA;
                     bit_idx_reg <= '0;
                  end else begin
                     state_reg <= ST_IDLE;
                     rx_busy   <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            // From the mid-start-bit reference, every full bit period lands
            // in the centre of the next bit.
            ST_DATA: begin
               if (cnt_reg == CNT_BIT_LAST) begin
                  cnt_reg                <= '0;
                  shift_reg[bit_idx_reg] <= rx_s;
                  if (bit_idx_reg == LAST_BIT_IDX) begin
                     state_reg <= ST_STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            // Returning to IDLE at mid-stop-bit leaves half a bit of margin
            // for a start bit that follows immediately.
            ST_STOP: begin
               if (cnt_reg == CNT_BIT_LAST) begin
                  cnt_reg <= '0;
                  if (rx_s) begin
                     rx_data       <= shift_reg;
                     rx_data_valid <= 1'b1;
                     state_reg     <= ST_IDLE;
                     rx_busy       <= 1'b0;
                  end else begin
                     framing_error <= 1'b1;
                     state_reg     <= ST_WAIT_IDLE;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            // A line held low (break) must not be read as a stream of
            // start bits; wait for it to return high first.
            ST_WAIT_IDLE: begin
               cnt_reg <= '0;
               if (rx_s) begin
                  state_reg <= ST_IDLE;
                  rx_busy   <= 1'b0;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
               rx_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//  Drives rx_in bit-serially with CLKS_PER_BIT=8. Every frame sent pushes the
//  event it should cause (cycle, valid-or-error, rx_data) onto an expected
//  queue; a negedge monitor collects the events the receiver actually
//  produced, and the two queues are compared after each group of frames.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB  = 8;
   localparam int HALF = CPB / 2;
   // Event edge relative to edge k: 2 sync stages, half bit, 9 full bits.
   localparam int EVT_LAT = 2 + HALF + 9 * CPB;

   typedef struct {
      int         cyc;
      bit         err;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_busy;
   logic       framing_error;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         both_cnt = 0;
   logic [7:0] last_good = 8'h00;
   ev_t        exp_q[$];
   ev_t        obs_q[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_in         (rx_in),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_busy       (rx_busy),
      .framing_error (framing_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_data_valid || framing_error) begin
         obs_q.push_back('{cyc, framing_error, rx_data});
         $display("event cyc=%0d valid=%0b err=%0b rx_data=%02h",
                  cyc, rx_data_valid, framing_error, rx_data);
      end
      if (rx_data_valid && framing_error) both_cnt++;
   end

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns just after a rising edge so inputs never change at an edge.
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one 8N1 frame and records what the receiver should report.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      int k;
      k = cyc + 1;
      exp_q.push_back('{k + EVT_LAT, !stop_ok, stop_ok ? b : last_good});
      if (stop_ok) last_good = b;
      $display("send byte=%02h stop_ok=%0b k=%0d", b, stop_ok, k);
      rx_in = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         wait_cycles(CPB);
      end
      rx_in = stop_ok;
      wait_cycles(CPB);
      rx_in = 1'b1;
   endtask

   task automatic check_events(input string tag);
      int n;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
         chk({tag, "_err"},  32'(obs_q[i].err), 32'(exp_q[i].err));
         chk({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      bit         ok;
      int         gap;
      int         k;

      // Reset state
      reset = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rx_data", 32'(rx_data), 32'h00);
      chk("rst_valid", 32'(rx_data_valid), 32'h0);
      chk("rst_busy", 32'(rx_busy), 32'h0);
      chk("rst_ferr", 32'(framing_error), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_cycles(2 * CPB);
      chk("idle_no_events", obs_q.size(), 0);

      // Single byte
      send_frame(8'h55, 1'b1);
      wait_cycles(2 * CPB);
      chk("t1_busy_low", 32'(rx_busy), 32'h0);
      check_events("t1");

      // Back-to-back frames, one stop bit, no gap
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0F, 1'b1);
      wait_cycles(2 * CPB);
      if (obs_q.size() == 2) chk("t2_spacing", obs_q[1].cyc - obs_q[0].cyc, 10 * CPB);
      check_events("t2");

      // Three-cycle low glitch
      k = cyc + 1;
      rx_in = 1'b0;
      wait_cycles(3);
      rx_in = 1'b1;
      chk("t3_busy_high", 32'(rx_busy), 32'h1);
      repeat (k + 7 - cyc) @(posedge clk);
      @(negedge clk);
      chk("t3_busy_low", 32'(rx_busy), 32'h0);
      wait_cycles(2 * CPB);
      check_events("t3");

      // Low stop bit, then a 40-cycle break
      send_frame(8'h41, 1'b0);
      rx_in = 1'b0;
      wait_cycles(40);
      chk("t4_busy_break", 32'(rx_busy), 32'h1);
      rx_in = 1'b1;
      wait_cycles(4);
      chk("t4_busy_low", 32'(rx_busy), 32'h0);
      chk("t4_rx_data", 32'(rx_data), 32'(last_good));
      wait_cycles(2 * CPB);
      check_events("t4");

      // Reset during data bit 4 of 0x3C
      b = 8'h3C;
      rx_in = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_in = b[i];
         wait_cycles(CPB);
      end
      rx_in = b[4];
      wait_cycles(HALF);
      chk("t5_busy_before", 32'(rx_busy), 32'h1);
      reset = 1'b1;
      rx_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_busy_rst", 32'(rx_busy), 32'h0);
      chk("t5_rx_data_rst", 32'(rx_data), 32'h00);
      last_good = 8'h00;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_cycles(2 * CPB);
      send_frame(8'h7E, 1'b1);
      wait_cycles(2 * CPB);
      check_events("t5");

      // All-zero then all-one data
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_cycles(2 * CPB);
      check_events("t6");

      // Random frames, random gaps, occasional bad stop bit
      for (int n = 0; n < 10; n++) begin
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         send_frame(b, ok);
         gap = ok ? $urandom_range(0, 2) * CPB : CPB + $urandom_range(0, CPB);
         if (gap > 0) wait_cycles(gap);
      end
      wait_cycles(2 * CPB);
      check_events("rand");
      chk("rand_busy_low", 32'(rx_busy), 32'h0);

      chk("valid_err_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
